// File: rtl/dog_extrema_detect.sv
// DoG scale-space extrema detector: four DoG layers, 2-line buffers, 3x3x3 strict extrema on D1/D2.
// Optional contrast gate on |centre| >= thr enabled by defining DOG_CONTRAST_TH_EN.
module dog_extrema_detect #(
  parameter int dataW  = 8,
  parameter int frameW = 640,
  parameter int frameH = 480,
  parameter int BORDER = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       sof,
  input  logic [5*dataW-1:0]         dataIn,
  input  logic [dataW-1:0]           thr,
  output logic                       kpValid,
  output logic [$clog2(frameW)-1:0]  kpX,
  output logic [$clog2(frameH)-1:0]  kpY,
  output logic                       kpLayer,
  output logic                       kpMax,
  output logic signed [dataW:0]      kpDog
);
  localparam int XW = $clog2(frameW);
  localparam int YW = $clog2(frameH);
  localparam int DW = dataW + 1;
  localparam logic [XW-1:0] X_LO = XW'(BORDER);
  localparam logic [XW-1:0] X_HI = XW'(frameW - 1 - BORDER);
  localparam logic [YW-1:0] Y_LO = YW'(BORDER);
  localparam logic [YW-1:0] Y_HI = YW'(frameH - 1 - BORDER);
  typedef logic signed [DW-1:0] dog_t;

  logic [XW-1:0] x, px, px_s1, cx_c, cx_s2;
  logic [YW-1:0] y, py, py_s1, cy_c, cy_s2;
  logic          v_s1, v_s2, in_c;
  dog_t          d_now [4];
  dog_t          lb0 [4][frameW];
  dog_t          lb1 [4][frameW];
  dog_t          d_s1 [4];
  dog_t          r0_s1 [4];
  dog_t          r1_s1 [4];
  dog_t          win [4][2][3];
  dog_t          w [4][3][3];
  dog_t          cen [2];
  dog_t          c_s2 [2];
  logic [26:0]   gt_c [2];
  logic [26:0]   lt_c [2];
  logic [25:0]   gt_s2 [2];
  logic [25:0]   lt_s2 [2];
  logic [1:0]    ok_c, ok_s2;
  logic          hit1, hit2, hit;

  // sof tags the current pixel as (0,0) regardless of the counters
  assign px = sof ? '0 : x;
  assign py = sof ? '0 : y;

  always_comb begin
    for (int k = 0; k < 4; k++)
      d_now[k] = $signed({1'b0, dataIn[(k+1)*dataW +: dataW]}) - $signed({1'b0, dataIn[k*dataW +: dataW]});
  end

  // Line buffers, window columns and data pipeline carry no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        lb0[k][px]   <= d_now[k];
        lb1[k][px]   <= lb0[k][px];
        d_s1[k]      <= d_now[k];
        r0_s1[k]     <= lb0[k][px];
        r1_s1[k]     <= lb1[k][px];
        win[k][0]    <= win[k][1];
        win[k][1]    <= '{r1_s1[k], r0_s1[k], d_s1[k]};
      end
      for (int l = 0; l < 2; l++) begin
        gt_s2[l] <= {gt_c[l][26:14], gt_c[l][12:0]};
        lt_s2[l] <= {lt_c[l][26:14], lt_c[l][12:0]};
        c_s2[l]  <= cen[l];
      end
      cx_s2 <= cx_c;
      cy_s2 <= cy_c;
    end
  end

  // Window columns px-2, px-1 come from the shift register; column px is the S1 stage.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++) begin
        w[k][0][r] = win[k][0][r];
        w[k][1][r] = win[k][1][r];
      end
      w[k][2][0] = r1_s1[k];
      w[k][2][1] = r0_s1[k];
      w[k][2][2] = d_s1[k];
    end
  end

  assign cx_c = (px_s1 == '0) ? XW'(frameW - 1) : px_s1 - 1'b1;
  assign cy_c = (py_s1 == '0) ? YW'(frameH - 1) : py_s1 - 1'b1;
  assign in_c = (cx_c >= X_LO) && (cx_c <= X_HI) && (cy_c >= Y_LO) && (cy_c <= Y_HI);

`ifdef DOG_CONTRAST_TH_EN
  logic [DW-1:0] mag [2];
`else
  logic thr_unused;
  assign thr_unused = ^thr;
`endif

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      cen[l]  = w[l+1][1][1];
      gt_c[l] = '0;
      lt_c[l] = '0;
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++) begin
            gt_c[l][k*9+c*3+r] = cen[l] > w[l+k][c][r];
            lt_c[l][k*9+c*3+r] = cen[l] < w[l+k][c][r];
          end
      gt_c[l][13] = 1'b1;
      lt_c[l][13] = 1'b1;
`ifdef DOG_CONTRAST_TH_EN
      mag[l]  = cen[l][DW-1] ? DW'(-cen[l]) : DW'(cen[l]);
      ok_c[l] = in_c && (mag[l] >= {1'b0, thr});
`else
      ok_c[l] = in_c;
`endif
    end
  end

  assign hit1 = v_s2 && ok_s2[0] && ((&gt_s2[0]) || (&lt_s2[0]));
  assign hit2 = v_s2 && ok_s2[1] && ((&gt_s2[1]) || (&lt_s2[1]));
  assign hit  = hit1 || hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0; y <= '0; px_s1 <= '0; py_s1 <= '0;
      v_s1 <= 1'b0; v_s2 <= 1'b0; ok_s2 <= '0;
      kpValid <= 1'b0; kpX <= '0; kpY <= '0;
      kpLayer <= 1'b0; kpMax <= 1'b0; kpDog <= '0;
    end else begin
      kpValid <= en && hit;
      if (en) begin
        if (px == XW'(frameW - 1)) begin
          x <= '0;
          y <= (py == YW'(frameH - 1)) ? '0 : py + 1'b1;
        end else begin
          x <= px + 1'b1;
          y <= py;
        end
        px_s1 <= px;
        py_s1 <= py;
        v_s1  <= 1'b1;
        v_s2  <= v_s1;
        ok_s2 <= v_s1 ? ok_c : 2'b00;
        // D1 wins when both layers hit the same centre
        if (hit) begin
          kpX     <= cx_s2;
          kpY     <= cy_s2;
          kpLayer <= !hit1;
          kpMax   <= hit1 ? (&gt_s2[0]) : (&gt_s2[1]);
          kpDog   <= hit1 ? c_s2[0] : c_s2[1];
        end
      end
    end
  end
endmodule

// File: tb/tb_dog_extrema_detect.sv
// Directed bench for dog_extrema_detect on a reduced 40x32 frame.
module tb_dog_extrema_detect;
  localparam int W = 40;
  localparam int H = 32;
  localparam logic [39:0] FLAT = {5{8'd100}};

  logic        clk = 1'b0;
  logic        rst, en, sof;
  logic [39:0] dataIn;
  logic [7:0]  thr;
  logic        kpValid, kpLayer, kpMax;
  logic [5:0]  kpX;
  logic [4:0]  kpY;
  logic signed [8:0] kpDog;

  int total = 0;
  int bad = 0;
  int pulses, pulse_edge;
  int imp_n;
  int imp_x [4];
  int imp_y [4];
  logic [39:0] imp_l [4];

  dog_extrema_detect #(.dataW(8), .frameW(W), .frameH(H), .BORDER(10)) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof), .dataIn(dataIn), .thr(thr),
    .kpValid(kpValid), .kpX(kpX), .kpY(kpY), .kpLayer(kpLayer), .kpMax(kpMax), .kpDog(kpDog)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] mk(input int g0, g1, g2, g3, g4);
    return {8'(g4), 8'(g3), 8'(g2), 8'(g1), 8'(g0)};
  endfunction

  function automatic logic [39:0] lanes(input int px, input int py);
    logic [39:0] v;
    v = FLAT;
    for (int i = 0; i < imp_n; i++)
      if (imp_x[i] == px && imp_y[i] == py) v = imp_l[i];
    return v;
  endfunction

  // Streams one frame; optional random en and an optional reset at the start of rst_row.
  task automatic run_frame(input bit rnd_en, input int rst_row);
    int pix, edges;
    bit did_rst;
    pix = 0; edges = 0; did_rst = 0; pulses = 0; pulse_edge = -1;
    for (int cyc = 0; cyc < 20000 && pix < W*H; cyc++) begin
      if (rst_row >= 0 && !did_rst && pix == rst_row*W) begin
        rst = 1'b1; en = 1'b0; sof = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; did_rst = 1; pix = 0; edges = 0;
      end
      en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      sof = (pix == 0);
      dataIn = lanes(pix % W, pix / W);
      @(posedge clk); #1;
      if (en) begin pix++; edges++; end
      if (kpValid) begin pulses++; pulse_edge = edges - 1; end
    end
    en = 1'b0; sof = 1'b0;
    total++;
    if (pix < W*H) begin bad++; $display("FAIL frame_timeout pixels=%0d required=%0d", pix, W*H); end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; sof = 1'b0; dataIn = FLAT; thr = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (kpValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", kpValid); end
    total++; if (kpX !== 6'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", kpX); end
    total++; if (kpY !== 5'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", kpY); end
    total++; if (kpLayer !== 1'b0) begin bad++; $display("FAIL reset_layer got=%b exp=0", kpLayer); end
    total++; if (kpMax !== 1'b0) begin bad++; $display("FAIL reset_max got=%b exp=0", kpMax); end
    total++; if (kpDog !== 9'sd0) begin bad++; $display("FAIL reset_dog got=%0d exp=0", kpDog); end
    rst = 1'b0;
  endtask

  task automatic test_flat;
    imp_n = 0; thr = 8'd0;
    run_frame(0, -1);
    total++; if (pulses !== 0) begin bad++; $display("FAIL flat_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_impulse;
    imp_n = 1; imp_x[0] = 20; imp_y[0] = 20; imp_l[0] = mk(100, 100, 140, 140, 140); thr = 8'd10;
    run_frame(0, -1);
    total++; if (pulses !== 1) begin bad++; $display("FAIL imp_pulses got=%0d exp=1", pulses); end
    total++; if (pulse_edge !== 21*W + 21 + 2) begin bad++; $display("FAIL imp_latency got=%0d exp=%0d", pulse_edge, 21*W + 23); end
    total++; if (kpX !== 6'd20) begin bad++; $display("FAIL imp_x got=%0d exp=20", kpX); end
    total++; if (kpY !== 5'd20) begin bad++; $display("FAIL imp_y got=%0d exp=20", kpY); end
    total++; if (kpLayer !== 1'b0) begin bad++; $display("FAIL imp_layer got=%b exp=0", kpLayer); end
    total++; if (kpMax !== 1'b1) begin bad++; $display("FAIL imp_max got=%b exp=1", kpMax); end
    total++; if (kpDog !== 9'sd40) begin bad++; $display("FAIL imp_dog got=%0d exp=40", kpDog); end
  endtask

  task automatic test_low_contrast;
    imp_n = 1; imp_x[0] = 20; imp_y[0] = 20; imp_l[0] = mk(100, 100, 105, 105, 105); thr = 8'd10;
    run_frame(0, -1);
`ifdef DOG_CONTRAST_TH_EN
    total++; if (pulses !== 0) begin bad++; $display("FAIL lowc_pulses got=%0d exp=0", pulses); end
`else
    total++; if (pulses !== 1) begin bad++; $display("FAIL lowc_pulses got=%0d exp=1", pulses); end
    total++; if (kpDog !== 9'sd5) begin bad++; $display("FAIL lowc_dog got=%0d exp=5", kpDog); end
`endif
  endtask

  task automatic test_tie;
    imp_n = 2; thr = 8'd10;
    imp_x[0] = 20; imp_y[0] = 20; imp_l[0] = mk(100, 100, 140, 140, 140);
    imp_x[1] = 21; imp_y[1] = 20; imp_l[1] = mk(100, 100, 140, 140, 140);
    run_frame(0, -1);
    total++; if (pulses !== 0) begin bad++; $display("FAIL tie_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_inverted;
    imp_n = 1; imp_x[0] = 20; imp_y[0] = 20; imp_l[0] = mk(100, 100, 60, 60, 60); thr = 8'd10;
    run_frame(0, -1);
    total++; if (pulses !== 1) begin bad++; $display("FAIL inv_pulses got=%0d exp=1", pulses); end
    total++; if (kpMax !== 1'b0) begin bad++; $display("FAIL inv_max got=%b exp=0", kpMax); end
    total++; if (kpDog !== -9'sd40) begin bad++; $display("FAIL inv_dog got=%0d exp=-40", kpDog); end
    total++; if (kpLayer !== 1'b0) begin bad++; $display("FAIL inv_layer got=%b exp=0", kpLayer); end
  endtask

  task automatic test_border;
    imp_n = 2; thr = 8'd10;
    imp_x[0] = 5;  imp_y[0] = 20;    imp_l[0] = mk(100, 100, 140, 140, 140);
    imp_x[1] = 20; imp_y[1] = H - 3; imp_l[1] = mk(100, 100, 140, 140, 140);
    run_frame(0, -1);
    total++; if (pulses !== 0) begin bad++; $display("FAIL border_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_layer2;
    imp_n = 1; imp_x[0] = 25; imp_y[0] = 15; imp_l[0] = mk(100, 100, 100, 140, 140); thr = 8'd10;
    run_frame(0, -1);
    total++; if (pulses !== 1) begin bad++; $display("FAIL l2_pulses got=%0d exp=1", pulses); end
    total++; if (kpLayer !== 1'b1) begin bad++; $display("FAIL l2_layer got=%b exp=1", kpLayer); end
    total++; if (kpX !== 6'd25) begin bad++; $display("FAIL l2_x got=%0d exp=25", kpX); end
    total++; if (kpY !== 5'd15) begin bad++; $display("FAIL l2_y got=%0d exp=15", kpY); end
    total++; if (kpDog !== 9'sd40) begin bad++; $display("FAIL l2_dog got=%0d exp=40", kpDog); end
  endtask

  task automatic test_dual_hit;
    // D1=+40 is a maximum and D2=-40 a minimum at the same centre
    imp_n = 1; imp_x[0] = 18; imp_y[0] = 12; imp_l[0] = mk(100, 100, 140, 100, 100); thr = 8'd10;
    run_frame(0, -1);
    total++; if (pulses !== 1) begin bad++; $display("FAIL dual_pulses got=%0d exp=1", pulses); end
    total++; if (kpLayer !== 1'b0) begin bad++; $display("FAIL dual_layer got=%b exp=0", kpLayer); end
    total++; if (kpMax !== 1'b1) begin bad++; $display("FAIL dual_max got=%b exp=1", kpMax); end
    total++; if (kpDog !== 9'sd40) begin bad++; $display("FAIL dual_dog got=%0d exp=40", kpDog); end
  endtask

  task automatic test_en_toggle;
    imp_n = 1; imp_x[0] = 20; imp_y[0] = 20; imp_l[0] = mk(100, 100, 140, 140, 140); thr = 8'd10;
    run_frame(1, -1);
    total++; if (pulses !== 1) begin bad++; $display("FAIL en_pulses got=%0d exp=1", pulses); end
    total++; if (pulse_edge !== 21*W + 21 + 2) begin bad++; $display("FAIL en_latency got=%0d exp=%0d", pulse_edge, 21*W + 23); end
    total++; if (kpX !== 6'd20) begin bad++; $display("FAIL en_x got=%0d exp=20", kpX); end
    total++; if (kpY !== 5'd20) begin bad++; $display("FAIL en_y got=%0d exp=20", kpY); end
    total++; if (kpDog !== 9'sd40) begin bad++; $display("FAIL en_dog got=%0d exp=40", kpDog); end
  endtask

  task automatic test_reset_midframe;
    imp_n = 1; imp_x[0] = 20; imp_y[0] = 20; imp_l[0] = mk(100, 100, 140, 140, 140); thr = 8'd10;
    run_frame(0, 15);
    total++; if (pulses !== 1) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=1", pulses); end
    total++; if (pulse_edge !== 21*W + 21 + 2) begin bad++; $display("FAIL rstmid_latency got=%0d exp=%0d", pulse_edge, 21*W + 23); end
    total++; if (kpX !== 6'd20) begin bad++; $display("FAIL rstmid_x got=%0d exp=20", kpX); end
    total++; if (kpY !== 5'd20) begin bad++; $display("FAIL rstmid_y got=%0d exp=20", kpY); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sof = 1'b0; dataIn = FLAT; thr = 8'd0; imp_n = 0;
    test_reset;
    test_flat;
    test_impulse;
    test_low_contrast;
    test_tie;
    test_inverted;
    test_border;
    test_layer2;
    test_dual_hit;
    test_en_toggle;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dog_extrema_detect.md
# dog_extrema_detect

Consumes the five Gaussian-blurred pixel lanes produced each enabled clock by the octave blur stage. Forms four Difference-of-Gaussian (DoG) layers, buffers two raster lines of each, and flags strict 3×3×3 scale-space extrema on the two interior DoG layers. Emits one keypoint record per hit to the downstream orientation/descriptor stage.

## Interface
- `dataW`, 8: bits per blurred lane.
- `frameW`, 640: pixels per line.
- `frameH`, 480: lines per frame.
- `BORDER`, 10: margin in pixels excluded on every side; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: pixel strobe/stall; all state advances only on edges with en=1.
- `sof` in 1: sampled with en; marks the first pixel of a frame.
- `dataIn` in 5·dataW: blurred lanes; `dataIn[k*dataW+:dataW]` = G_k, with k=0 the least blurred.
- `thr` in dataW: unsigned contrast threshold.
- `kpValid` out 1: one-cycle keypoint pulse.
- `kpX` out $clog2(frameW): centre column.
- `kpY` out $clog2(frameH): centre row.
- `kpLayer` out 1: 0 = D1, 1 = D2.
- `kpMax` out 1: 1 = maximum, 0 = minimum.
- `kpDog` out dataW+1: signed DoG value at the centre.

## Operation
- DoG: D_k = G_{k+1} − G_k for k=0..3, unsigned operands, signed two's-complement result of dataW+1 bits. No saturation is needed.
- Pixel counters x, y:
  - On an en edge: sof=1 loads x=1, y=0, tagging the current pixel as (0,0). Otherwise x increments.
  - x wraps frameW−1→0 with y+1; y wraps frameH−1→0.
- Line buffers: per layer, two lines of frameW×(dataW+1) bits, written at column x on each en edge. A 3×3 column shift register per layer completes the window.
- The window centre for the accepted pixel (x,y) is (x−1, y−1).
- Candidate test, run on D1 (neighbours D0,D1,D2) and on D2 (neighbours D1,D2,D3):
  - Maximum: centre > all 26 neighbours. Minimum: centre < all 26 neighbours. Both comparisons are signed and strict, so ties never qualify.
  - Contrast: |centre| ≥ thr, using the (dataW+1)-bit magnitude (see Configuration).
  - Border mask: BORDER ≤ cx ≤ frameW−1−BORDER and BORDER ≤ cy ≤ frameH−1−BORDER. Rows/columns that wrap across line or frame edges are always masked because BORDER≥1.
- Simultaneous hits on D1 and D2 at the same centre: report D1 only; the D2 hit is dropped.
- Line buffer RAM is not cleared by rst. Stale content is never reported because the row mask covers the first BORDER rows after sof or reset.

## Timing
- Three-stage pipeline, all stages qualified by en:
  - S1 registers DoG values and line-buffer reads.
  - S2 registers the 52 comparison results and masks.
  - S3 registers the outputs.
- Latency: the record for centre (cx,cy) appears after the 3rd en=1 rising edge, counting the edge that accepted pixel (cx+1, cy+1).
- kpValid on each edge is set to en & S2-hit, so it is high for exactly one clock. kpX/kpY/kpLayer/kpMax/kpDog hold their values until the next hit.
- en=0 freezes counters, line buffers and pipeline; kpValid goes low on that edge.
- Reset values: kpValid=0, kpX=0, kpY=0, kpLayer=0, kpMax=0, kpDog=0; x=0, y=0; pipeline valid bits cleared.
- rst mid-frame: the in-flight pipeline is discarded, with no kpValid for one edge after release. Counters restart at (0,0); the next pixel is treated as (0,0) even without sof.
- sof arriving mid-frame: counters resynchronise immediately; pipeline contents drain normally.

## Configuration
- `DOG_CONTRAST_TH_EN`
  - Defined: the |centre| ≥ thr test is applied.
  - Undefined: `thr` is ignored, and every strict, unmasked extremum is reported.

## Test plan
- Flat frame with all lanes at 100 and thr=0 → kpValid never asserts.
- Impulse at (20,20): G0=G1=100, G2=G3=G4=140; elsewhere all lanes 100; thr=10 → one pulse with kpX=20, kpY=20, kpLayer=0, kpMax=1, kpDog=+40, at latency 3 en-edges after pixel (21,21).
- Same impulse at amplitude 5 (G2..G4=105), thr=10 → no pulse with DOG_CONTRAST_TH_EN; one pulse with kpDog=+5 without it.
- Two horizontally adjacent impulses of equal value at (20,20) and (21,20) → no pulse (tie). Inverted impulse (G2..G4=60) at (20,20) → kpMax=0, kpDog=−40.
- Impulse at (5,20) and at (20,frameH−3) with BORDER=10 → no pulse.
- Impulse test from the second scenario with en toggling pseudo-randomly at 50% → identical record, with kpValid asserted on one clock only. rst asserted at row 15, then a new frame with sof → the impulse in the new frame is reported exactly once with correct coordinates.
